// File: rtl/car_controller.sv
// Purpose : per-frame lane traffic engine; one car per lane, pixel coverage lookup and player collision.
// Latency : pixel path combinational (0 cycles); Collision registered, high 1 Clk after the frame tick.
// Backpressure: none; all inputs are sampled every cycle, Pause freezes lane motion and respawn timers.
//
// Ports:
//   Clk, Reset            clock, synchronous active-high reset
//   frame_clk             vsync level; its rising edge (resynchronised to Clk) is one frame tick
//   Pause                 1 = hold all lane state and suppress Collision
//   DrawX, DrawY          current pixel coordinate
//   PlayerX, PlayerY      top-left corner of the 16x16 player hitbox
//   SpriteData            async car ROM data at SpriteAddr (0 = transparent)
//   SpriteAddr            {dir, row[3:0], col[4:0]} into the car ROM, 0 when no car covers the pixel
//   CarPixel              palette index of the covering car, 0 if none
//   CarPriority           1 = covering car's bottom row is below the player's bottom row
//   Collision             one-cycle pulse after a frame tick on which the player overlaps a moving car
//
// Build option: define CAR_LFSR_EN to randomise the respawn gap by 0..15 extra frames with a 16-bit LFSR.
module car_controller #(
  parameter int LANES      = 4,
  parameter int LANE_Y0    = 80,
  parameter int LANE_PITCH = 80,
  parameter int CAR_W      = 32,
  parameter int CAR_H      = 16,
  parameter int SCREEN_W   = 640,
  parameter int RESPAWN    = 30
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       frame_clk,
  input  logic       Pause,
  input  logic [9:0] DrawX,
  input  logic [9:0] DrawY,
  input  logic [9:0] PlayerX,
  input  logic [9:0] PlayerY,
  input  logic [5:0] SpriteData,
  output logic [9:0] SpriteAddr,
  output logic [5:0] CarPixel,
  output logic       CarPriority,
  output logic       Collision
);

  localparam int PLAYER_SZ = 16;

  // 12-bit signed working width keeps x + CAR_W and player + 16 free of overflow.
  localparam logic signed [11:0] SCREEN_W_S  = 12'(SCREEN_W);
  localparam logic signed [11:0] NEG_CAR_W_S = 12'(-CAR_W);
  localparam logic signed [11:0] CAR_W_S     = 12'(CAR_W);
  localparam logic signed [11:0] PLAYER_SZ_S = 12'(PLAYER_SZ);

  localparam logic signed [10:0] X_START_R = 11'sd0;
  localparam logic signed [10:0] X_START_L = 11'(SCREEN_W - CAR_W);
  localparam logic signed [10:0] X_EDGE_R  = 11'(SCREEN_W);
  localparam logic signed [10:0] X_EDGE_L  = 11'(-CAR_W);
  localparam logic [5:0]         WAIT_INIT = 6'(RESPAWN - 1);

  typedef enum logic {
    MOVING  = 1'b0,
    WAITING = 1'b1
  } lane_st_t;

  // ---------------------------------------------------------------------------
  // Frame tick: 2-flop synchroniser followed by rising-edge detect.
  // ---------------------------------------------------------------------------
  logic fsync1, fsync2, fprev;
  logic tick, step;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      fsync1 <= 1'b0;
      fsync2 <= 1'b0;
      fprev  <= 1'b0;
    end else begin
      fsync1 <= frame_clk;
      fsync2 <= fsync1;
      fprev  <= fsync2;
    end
  end

  assign tick = fsync2 & ~fprev;
  assign step = tick & ~Pause;

  // ---------------------------------------------------------------------------
  // Respawn gap load value.
  // ---------------------------------------------------------------------------
  logic [5:0] wait_load;

`ifdef CAR_LFSR_EN
  logic [15:0] lfsr_q;

  // Fibonacci LFSR, taps 16,14,13,11; advances on every frame tick.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      lfsr_q <= 16'hACE1;
    end else if (tick) begin
      lfsr_q <= {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
    end
  end

  assign wait_load = WAIT_INIT + {2'b00, lfsr_q[3:0]};
`else
  assign wait_load = WAIT_INIT;
`endif

  // ---------------------------------------------------------------------------
  // Per-lane state.
  // ---------------------------------------------------------------------------
  logic signed [10:0] x_q    [LANES];
  logic signed [10:0] x_d    [LANES];
  lane_st_t           st_q   [LANES];
  lane_st_t           st_d   [LANES];
  logic [5:0]         cnt_q  [LANES];
  logic [5:0]         cnt_d  [LANES];
  logic [10:0]        lane_y [LANES];
  logic signed [11:0] x_ext  [LANES];
  logic signed [11:0] x_nxt  [LANES];

  // Lane geometry and candidate next position; odd lanes travel leftward.
  always_comb begin
    for (int i = 0; i < LANES; i++) begin
      lane_y[i] = 11'(LANE_Y0 + i * LANE_PITCH);
      x_ext[i]  = {x_q[i][10], x_q[i]};
      if ((i % 2) != 0) begin
        x_nxt[i] = x_ext[i] - 12'(i + 1);
      end else begin
        x_nxt[i] = x_ext[i] + 12'(i + 1);
      end
    end
  end

  // Next-state logic for every lane.
  always_comb begin
    for (int i = 0; i < LANES; i++) begin
      x_d[i]   = x_q[i];
      st_d[i]  = st_q[i];
      cnt_d[i] = cnt_q[i];
      if (step) begin
        case (st_q[i])
          MOVING: begin
            if ((i % 2) != 0) begin
              if (x_nxt[i] <= NEG_CAR_W_S) begin
                st_d[i]  = WAITING;
                cnt_d[i] = wait_load;
                x_d[i]   = X_EDGE_L;
              end else begin
                x_d[i] = x_nxt[i][10:0];
              end
            end else begin
              if (x_nxt[i] >= SCREEN_W_S) begin
                st_d[i]  = WAITING;
                cnt_d[i] = wait_load;
                x_d[i]   = X_EDGE_R;
              end else begin
                x_d[i] = x_nxt[i][10:0];
              end
            end
          end
          WAITING: begin
            if (cnt_q[i] == 6'd0) begin
              // Re-enter from the edge opposite to the one the car left through.
              st_d[i] = MOVING;
              x_d[i]  = ((i % 2) != 0) ? X_EDGE_R : X_EDGE_L;
            end else begin
              cnt_d[i] = cnt_q[i] - 6'd1;
            end
          end
          default: begin
            st_d[i] = MOVING;
          end
        endcase
      end
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      for (int i = 0; i < LANES; i++) begin
        x_q[i]   <= ((i % 2) != 0) ? X_START_L : X_START_R;
        st_q[i]  <= MOVING;
        cnt_q[i] <= 6'd0;
      end
    end else begin
      for (int i = 0; i < LANES; i++) begin
        x_q[i]   <= x_d[i];
        st_q[i]  <= st_d[i];
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Pixel coverage and player overlap.
  // ---------------------------------------------------------------------------
  logic signed [11:0] dx_s, px_s;
  logic [10:0]        dy_u, py_u;
  logic [LANES-1:0]   covers;
  logic [LANES-1:0]   overlap;

  assign dx_s = $signed({2'b00, DrawX});
  assign px_s = $signed({2'b00, PlayerX});
  assign dy_u = {1'b0, DrawY};
  assign py_u = {1'b0, PlayerY};

  always_comb begin
    covers  = '0;
    overlap = '0;
    for (int i = 0; i < LANES; i++) begin
      covers[i] = (st_q[i] == MOVING) &&
                  (x_ext[i] <= dx_s) && (dx_s < x_ext[i] + CAR_W_S) &&
                  (dy_u >= lane_y[i]) && (dy_u < lane_y[i] + 11'(CAR_H));
      overlap[i] = (st_q[i] == MOVING) &&
                   (px_s < x_ext[i] + CAR_W_S) && (x_ext[i] < px_s + PLAYER_SZ_S) &&
                   (py_u < lane_y[i] + 11'(CAR_H)) && (lane_y[i] < py_u + 11'(PLAYER_SZ));
    end
  end

  // Scan from the highest lane down so the lowest covering lane is the last assignment.
  logic        hit;
  logic        sel_dir;
  logic [3:0]  sel_row;
  logic [4:0]  sel_col;
  logic [10:0] sel_bottom;

  always_comb begin
    hit        = 1'b0;
    sel_dir    = 1'b0;
    sel_row    = 4'd0;
    sel_col    = 5'd0;
    sel_bottom = 11'd0;
    for (int i = LANES - 1; i >= 0; i--) begin
      if (covers[i]) begin
        hit        = 1'b1;
        sel_dir    = (i % 2) != 0;
        // Low bits of the offsets equal the truncated full-width differences.
        sel_row    = DrawY[3:0] - lane_y[i][3:0];
        sel_col    = DrawX[4:0] - x_q[i][4:0];
        sel_bottom = lane_y[i] + 11'(CAR_H - 1);
      end
    end
  end

  assign SpriteAddr  = hit ? {sel_dir, sel_row, sel_col} : 10'd0;
  assign CarPixel    = hit ? SpriteData : 6'd0;
  assign CarPriority = hit && (sel_bottom > py_u + 11'd15);

  // Collision is judged against the positions held before this tick's update.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      Collision <= 1'b0;
    end else begin
      Collision <= step && (|overlap);
    end
  end

endmodule

// File: tb/tb_car_controller.sv
// Purpose : bench for car_controller (default build) plus a LANE_PITCH=8 instance for overlapping lanes.
// Latency : expects Collision three negedges after frame_clk rises (2-flop sync + registered output).
// Backpressure: none; the bench drives frames and probes pixels at negedges.
module tb_car_controller;

  logic       clk = 1'b0;
  logic       reset, frame_clk, pause, rom_zero;
  logic [9:0] draw_x, draw_y, player_x, player_y;
  logic [9:0] sa_a, sa_b;
  logic [5:0] sd_a, sd_b, pix_a, pix_b;
  logic       pri_a, pri_b, coll_a, coll_b;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  // Behavioural car ROM.
  function automatic logic [5:0] rom(input logic [9:0] a);
    logic [15:0] t;
    t = {6'b0, a} * 16'd13 + 16'd7;
    return t[5:0];
  endfunction

  assign sd_a = rom_zero ? 6'd0 : rom(sa_a);
  assign sd_b = rom_zero ? 6'd0 : rom(sa_b);

  car_controller dut_a (
    .Clk(clk), .Reset(reset), .frame_clk(frame_clk), .Pause(pause),
    .DrawX(draw_x), .DrawY(draw_y), .PlayerX(player_x), .PlayerY(player_y),
    .SpriteData(sd_a), .SpriteAddr(sa_a), .CarPixel(pix_a),
    .CarPriority(pri_a), .Collision(coll_a)
  );

  car_controller #(.LANE_PITCH(8)) dut_b (
    .Clk(clk), .Reset(reset), .frame_clk(frame_clk), .Pause(pause),
    .DrawX(draw_x), .DrawY(draw_y), .PlayerX(player_x), .PlayerY(player_y),
    .SpriteData(sd_b), .SpriteAddr(sa_b), .CarPixel(pix_b),
    .CarPriority(pri_b), .Collision(coll_b)
  );

  // ---------------------------------------------------------------------------
  // Reference model: car position per lane plus frames left until re-entry.
  // ---------------------------------------------------------------------------
  int mx   [4];
  bit mwait[4];
  int mgap [4];

  task automatic model_reset();
    for (int i = 0; i < 4; i++) begin
      mx[i]    = (i % 2 == 0) ? 0 : 608;
      mwait[i] = 0;
      mgap[i]  = 0;
    end
  endtask

  task automatic model_tick();
    for (int i = 0; i < 4; i++) begin
      if (!mwait[i]) begin
        if (i % 2 == 0) mx[i] = mx[i] + (i + 1);
        else            mx[i] = mx[i] - (i + 1);
        if (mx[i] >= 640 || mx[i] <= -32) begin
          mwait[i] = 1;
          mgap[i]  = 30;
        end
      end else begin
        mgap[i] = mgap[i] - 1;
        if (mgap[i] == 0) begin
          mwait[i] = 0;
          mx[i]    = (i % 2 == 0) ? -32 : 640;
        end
      end
    end
  endtask

  task automatic model_pixel(input int dx, input int dy, input int pitch,
                             output logic [9:0] addr, output logic [5:0] pix, output logic pri);
    bit found;
    int ly;
    found = 0;
    addr  = 10'd0;
    pix   = 6'd0;
    pri   = 1'b0;
    for (int i = 0; i < 4; i++) begin
      ly = 80 + i * pitch;
      if (!found && !mwait[i] && dx >= mx[i] && dx < mx[i] + 32 && dy >= ly && dy < ly + 16) begin
        found = 1;
        addr  = 10'((i % 2) * 512 + (dy - ly) * 32 + (dx - mx[i]));
        pix   = rom_zero ? 6'd0 : rom(addr);
        pri   = (ly + 15) > (int'(player_y) + 15);
      end
    end
  endtask

  function automatic bit model_coll(input int pitch);
    int px, py, ly;
    px = int'(player_x);
    py = int'(player_y);
    for (int i = 0; i < 4; i++) begin
      ly = 80 + i * pitch;
      if (!mwait[i] && px < mx[i] + 32 && mx[i] < px + 16 && py < ly + 16 && ly < py + 16)
        return 1;
    end
    return 0;
  endfunction

  // ---------------------------------------------------------------------------
  // Stimulus helpers (no comparisons inside).
  // ---------------------------------------------------------------------------
  logic [9:0] ea_addr, eb_addr;
  logic [5:0] ea_pix, eb_pix;
  logic       ea_pri, eb_pri;
  bit         exp_ca, exp_cb;
  int         ca_cnt, ca_at, cb_cnt, cb_at;

  task automatic do_frame(input int hold);
    exp_ca = !pause && model_coll(80);
    exp_cb = !pause && model_coll(8);
    ca_cnt = 0; ca_at = -1; cb_cnt = 0; cb_at = -1;
    @(negedge clk);
    frame_clk = 1'b1;
    for (int c = 1; c <= hold + 3; c++) begin
      if (c == hold + 1) frame_clk = 1'b0;
      @(negedge clk);
      if (coll_a === 1'b1) begin ca_cnt++; if (ca_at < 0) ca_at = c; end
      if (coll_b === 1'b1) begin cb_cnt++; if (cb_at < 0) cb_at = c; end
    end
    if (!pause) model_tick();
  endtask

  task automatic probe(input int dx, input int dy);
    @(negedge clk);
    draw_x = 10'(dx);
    draw_y = 10'(dy);
    #1;
    model_pixel(dx, dy, 80, ea_addr, ea_pix, ea_pri);
    model_pixel(dx, dy, 8,  eb_addr, eb_pix, eb_pri);
  endtask

  function automatic int clampx(input int v);
    return (v < 0) ? 0 : ((v > 1023) ? 1023 : v);
  endfunction

  // ---------------------------------------------------------------------------
  // Scenarios.
  // ---------------------------------------------------------------------------
  task automatic test_reset();
    int pts[6][2];
    pts = '{'{0, 80}, '{5, 83}, '{608, 160}, '{607, 160}, '{639, 175}, '{31, 95}};
    reset = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    model_reset();
    @(negedge clk);
    checks++;
    if (coll_a !== 1'b0 || coll_b !== 1'b0) begin
      errors++; $display("FAIL reset_collision got a=%b b=%b want 0", coll_a, coll_b);
    end
    for (int k = 0; k < 6; k++) begin
      probe(pts[k][0], pts[k][1]);
      checks++;
      if ({sa_a, pix_a, pri_a} !== {ea_addr, ea_pix, ea_pri}) begin
        errors++; $display("FAIL reset_pix_a (%0d,%0d) got %h want %h", pts[k][0], pts[k][1], {sa_a, pix_a, pri_a}, {ea_addr, ea_pix, ea_pri});
      end
      checks++;
      if ({sa_b, pix_b, pri_b} !== {eb_addr, eb_pix, eb_pri}) begin
        errors++; $display("FAIL reset_pix_b (%0d,%0d) got %h want %h", pts[k][0], pts[k][1], {sa_b, pix_b, pri_b}, {eb_addr, eb_pix, eb_pri});
      end
    end
  endtask

  task automatic test_pause();
    pause    = 1'b1;
    player_x = 10'd0;
    player_y = 10'd80;
    for (int f = 0; f < 3; f++) begin
      do_frame(6);
      checks++;
      if (ca_cnt != 0 || cb_cnt != 0) begin
        errors++; $display("FAIL pause_collision got a=%0d b=%0d pulses want 0", ca_cnt, cb_cnt);
      end
    end
    probe(0, 80);
    checks++;
    if ({sa_a, pix_a, pri_a} !== {ea_addr, ea_pix, ea_pri} || pix_a !== rom(10'd0)) begin
      errors++; $display("FAIL pause_pix got %h want %h", {sa_a, pix_a, pri_a}, {ea_addr, ea_pix, ea_pri});
    end
    pause = 1'b0;
  endtask

  task automatic test_one_tick();
    int pts[6][2];
    pts = '{'{0, 80}, '{1, 80}, '{605, 160}, '{606, 160}, '{603, 320}, '{604, 320}};
    // Player overlaps lane 1 only in the default-pitch instance.
    player_x = 10'd620;
    player_y = 10'd160;
    do_frame(100);
    checks++;
    if (ca_cnt != 1 || ca_at != 3 || !exp_ca) begin
      errors++; $display("FAIL long_vsync_coll_a got cnt=%0d at=%0d want cnt=1 at=3", ca_cnt, ca_at);
    end
    checks++;
    if (cb_cnt != 0) begin
      errors++; $display("FAIL long_vsync_coll_b got cnt=%0d want 0", cb_cnt);
    end
    for (int k = 0; k < 6; k++) begin
      probe(pts[k][0], pts[k][1]);
      checks++;
      if ({sa_a, pix_a, pri_a} !== {ea_addr, ea_pix, ea_pri}) begin
        errors++; $display("FAIL one_tick_pix (%0d,%0d) got %h want %h", pts[k][0], pts[k][1], {sa_a, pix_a, pri_a}, {ea_addr, ea_pix, ea_pri});
      end
    end
  endtask

  task automatic test_collision();
    player_x = 10'(mx[0] + 10);
    player_y = 10'd82;
    do_frame(6);
    checks++;
    if (ca_cnt != 1 || ca_at != 3) begin
      errors++; $display("FAIL collision_pulse got cnt=%0d at=%0d want cnt=1 at=3", ca_cnt, ca_at);
    end
    checks++;
    if (cb_cnt != (exp_cb ? 1 : 0) || (exp_cb && cb_at != 3)) begin
      errors++; $display("FAIL collision_pulse_b got cnt=%0d at=%0d want %0d", cb_cnt, cb_at, exp_cb);
    end
    // Player touching the car's right edge does not overlap.
    player_x = 10'(mx[0] + 32);
    do_frame(6);
    checks++;
    if (ca_cnt != 0) begin
      errors++; $display("FAIL collision_edge got cnt=%0d want 0", ca_cnt);
    end
    player_y = 10'd70;
    probe(mx[0] + 3, 85);
    checks++;
    if (pri_a !== 1'b1 || {sa_a, pix_a, pri_a} !== {ea_addr, ea_pix, ea_pri}) begin
      errors++; $display("FAIL priority_above got %h want %h", {sa_a, pix_a, pri_a}, {ea_addr, ea_pix, ea_pri});
    end
    player_y = 10'd90;
    probe(mx[0] + 3, 85);
    checks++;
    if (pri_a !== 1'b0 || {sa_a, pix_a, pri_a} !== {ea_addr, ea_pix, ea_pri}) begin
      errors++; $display("FAIL priority_below got %h want %h", {sa_a, pix_a, pri_a}, {ea_addr, ea_pix, ea_pri});
    end
  endtask

  task automatic test_reset_tick();
    int cnt;
    player_x = 10'(mx[0] + 10);
    player_y = 10'd82;
    @(negedge clk);
    frame_clk = 1'b1;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;      // reset lands on the same edge as the tick
    @(negedge clk);
    reset     = 1'b0;
    frame_clk = 1'b0;
    model_reset();
    cnt = 0;
    for (int c = 0; c < 6; c++) begin
      if (coll_a === 1'b1 || coll_b === 1'b1) cnt++;
      @(negedge clk);
    end
    checks++;
    if (cnt != 0) begin
      errors++; $display("FAIL reset_tick_collision got %0d pulses want 0", cnt);
    end
    probe(0, 80);
    checks++;
    if ({sa_a, pix_a, pri_a} !== {ea_addr, ea_pix, ea_pri} || sa_a !== 10'd0 || pix_a === 6'd0) begin
      errors++; $display("FAIL reset_tick_lane0 got %h want %h", {sa_a, pix_a, pri_a}, {ea_addr, ea_pix, ea_pri});
    end
    probe(608, 160);
    checks++;
    if ({sa_a, pix_a, pri_a} !== {ea_addr, ea_pix, ea_pri} || sa_a !== 10'd512) begin
      errors++; $display("FAIL reset_tick_lane1 got %h want %h", {sa_a, pix_a, pri_a}, {ea_addr, ea_pix, ea_pri});
    end
  endtask

  task automatic test_coverage();
    bit done;
    int dx;
    done     = 0;
    player_x = 10'd600;
    player_y = 10'd0;
    for (int f = 0; f < 300 && !done; f++) begin
      do_frame(4);
      if (!mwait[0] && !mwait[1] && mx[0] < mx[1] + 32 && mx[1] < mx[0] + 32) begin
        done = 1;
        dx   = (mx[0] > mx[1]) ? mx[0] : mx[1];
        probe(dx, 90);
        checks++;
        if ({sa_b, pix_b, pri_b} !== {eb_addr, eb_pix, eb_pri} || sa_b[9] !== 1'b0) begin
          errors++; $display("FAIL overlap_lowest_lane got %h want %h", {sa_b, pix_b, pri_b}, {eb_addr, eb_pix, eb_pri});
        end
        rom_zero = 1'b1;
        probe(dx, 90);
        checks++;
        if (pix_b !== 6'd0 || sa_b !== eb_addr) begin
          errors++; $display("FAIL transparent got pix=%0d addr=%0d want pix=0 addr=%0d", pix_b, sa_b, eb_addr);
        end
        rom_zero = 1'b0;
      end
    end
    checks++;
    if (!done) begin
      errors++; $display("FAIL overlap_timeout got no overlap want overlap within 300 frames");
    end
  endtask

  task automatic test_wrap();
    bit reached;
    int ln, dy;
    reached = 0;
    for (int f = 0; f < 1500 && !reached; f++) begin
      pause    = ($urandom_range(0, 7) == 0);
      player_x = 10'($urandom_range(0, 700));
      player_y = 10'($urandom_range(60, 340));
      do_frame(4);
      checks++;
      if (ca_cnt != (exp_ca ? 1 : 0) || (exp_ca && ca_at != 3) || cb_cnt != (exp_cb ? 1 : 0) || (exp_cb && cb_at != 3)) begin
        errors++; $display("FAIL rand_coll f=%0d got a=%0d@%0d b=%0d@%0d want a=%0d b=%0d", f, ca_cnt, ca_at, cb_cnt, cb_at, exp_ca, exp_cb);
      end
      ln = $urandom_range(0, 3);
      dy = 80 + ln * 80 + $urandom_range(0, 17) - 1;
      probe(clampx(mx[ln] + $urandom_range(0, 35) - 2), dy);
      checks++;
      if ({sa_a, pix_a, pri_a} !== {ea_addr, ea_pix, ea_pri}) begin
        errors++; $display("FAIL rand_edge_a (%0d,%0d) got %h want %h", draw_x, draw_y, {sa_a, pix_a, pri_a}, {ea_addr, ea_pix, ea_pri});
      end
      probe($urandom_range(0, 700), $urandom_range(76, 124));
      checks++;
      if ({sa_b, pix_b, pri_b} !== {eb_addr, eb_pix, eb_pri}) begin
        errors++; $display("FAIL rand_pix_b (%0d,%0d) got %h want %h", draw_x, draw_y, {sa_b, pix_b, pri_b}, {eb_addr, eb_pix, eb_pri});
      end
      reached = (mx[0] == 639) && !mwait[0];
    end
    checks++;
    if (!reached) begin
      errors++; $display("FAIL wrap_timeout got lane0 x=%0d want 639", mx[0]);
    end
    pause    = 1'b0;
    player_x = 10'd0;
    player_y = 10'd0;
    for (int k = 1; k <= 32; k++) begin
      do_frame(4);
      probe(639, 80);
      checks++;
      if ({sa_a, pix_a, pri_a} !== {ea_addr, ea_pix, ea_pri}) begin
        errors++; $display("FAIL respawn_right k=%0d got %h want %h", k, {sa_a, pix_a, pri_a}, {ea_addr, ea_pix, ea_pri});
      end
      probe(0, 80);
      checks++;
      if ({sa_a, pix_a, pri_a} !== {ea_addr, ea_pix, ea_pri} || (k < 32 && pix_a !== 6'd0) || (k == 32 && sa_a !== 10'd31)) begin
        errors++; $display("FAIL respawn_left k=%0d got %h want %h", k, {sa_a, pix_a, pri_a}, {ea_addr, ea_pix, ea_pri});
      end
    end
  endtask

  initial begin
    reset     = 1'b1;
    frame_clk = 1'b0;
    pause     = 1'b0;
    rom_zero  = 1'b0;
    draw_x    = 10'd0;
    draw_y    = 10'd0;
    player_x  = 10'd600;
    player_y  = 10'd0;
    model_reset();
    test_reset();
    test_pause();
    test_one_tick();
    test_collision();
    test_reset_tick();
    test_coverage();
    test_wrap();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
